// File: rtl/game2048_core_param_if.sv
// Control/observation bus of the sliding-tile engine: debounced buttons and
// the debug grid load port go in; grid snapshot, score and game status come out.
interface game2048_core_param_if #(
  parameter int N  = 4,
  parameter int TW = 4,
  parameter int SW = 16
);
  logic              mov_right;
  logic              mov_left;
  logic              mov_up;
  logic              mov_down;
  logic              load_en;
  logic [N*N*TW-1:0] load_grid;
  logic [N*N*TW-1:0] grid;
  logic [SW-1:0]     score;
  logic [3:0]        state_o;
  logic              busy;
  logic              win;
  logic              lose;

  modport master (
    output mov_right, mov_left, mov_up, mov_down, load_en, load_grid,
    input  grid, score, state_o, busy, win, lose
  );

  modport slave (
    input  mov_right, mov_left, mov_up, mov_down, load_en, load_grid,
    output grid, score, state_o, busy, win, lose
  );
endinterface

// File: rtl/game2048_core_param.sv
// N x N sliding-tile engine. Slides one line per cycle with a per-move merge
// lock, spawns tiles from a Galois LFSR, keeps a saturating score and detects
// win/lose. Cells hold exponents: 0 = empty, e = tile 2^e.
module game2048_core_param #(
  parameter int          N       = 4,
  parameter int          TW      = 4,
  parameter int          WIN_EXP = 11,
  parameter int          SW      = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic                  clk,
  input logic                  reset,
  game2048_core_param_if.slave bus
);
  localparam int NN = N * N;
  localparam int LW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int GW = $clog2(NN);
  localparam logic [TW-1:0] T0   = {TW{1'b0}};
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};
  localparam logic [SW-1:0] SMAX = {SW{1'b1}};

  typedef enum logic [3:0] {
    S_INIT = 4'd0, S_FIRST_GEN = 4'd1, S_PLAY = 4'd2, S_SLIDE = 4'd3,
    S_CHECK = 4'd4, S_GEN = 4'd5, S_WIN = 4'd6, S_LOSE = 4'd7
  } state_t;
  typedef enum logic [1:0] {D_RIGHT = 2'd0, D_LEFT = 2'd1, D_UP = 2'd2, D_DOWN = 2'd3} dir_t;

  // Cell index of element k (k = 0 is the leading end) of line 'line' for direction d.
  function automatic logic [GW-1:0] cell_index(input dir_t d, input logic [LW-1:0] line, input int k);
    int idx;
    case (d)
      D_RIGHT: idx = int'(line) * N + (N - 1 - k);
      D_LEFT:  idx = int'(line) * N + k;
      D_UP:    idx = k * N + int'(line);
      D_DOWN:  idx = (N - 1 - k) * N + int'(line);
      default: idx = 0;
    endcase
    return GW'(idx);
  endfunction

  state_t          state_r, state_s;
  dir_t            dir_r, dir_sel_s;
  logic [LW-1:0]   line_r;
  logic [TW-1:0]   cells_r [NN];
  logic [SW-1:0]   score_r, score_nxt_s;
  logic [15:0]     lfsr_r, lfsr_nxt_s;
  logic [3:0]      prev_r, cur_s, fall_s;
  logic            req_s, changed_r, first_r, busy_r, win_r, lose_r;
  logic [TW-1:0]   line_in_s [N];
  logic [TW-1:0]   comp_s [N+1];
  logic [TW-1:0]   line_out_s [N];
  logic [31:0]     add_s;
  logic [63:0]     sum_s;
  logic            diff_s, gen_found_s, win_hit_s, empty_s, pair_s;
  logic [GW-1:0]   gen_idx_s;
  logic [TW-1:0]   gen_val_s;
  logic [NN*TW-1:0] grid_s;

  // Button order {right, left, up, down}; a request is a registered 1->0 edge.
  assign cur_s      = {bus.mov_right, bus.mov_left, bus.mov_up, bus.mov_down};
  assign fall_s     = prev_r & ~cur_s;
  assign req_s      = |fall_s;
  assign lfsr_nxt_s = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
  assign sum_s      = 64'(score_r) + 64'(add_s);
  assign score_nxt_s = (sum_s > 64'(SMAX)) ? SMAX : SW'(sum_s);

  // Simultaneous requests resolve right > left > up > down.
  always_comb begin
    if (fall_s[3])      dir_sel_s = D_RIGHT;
    else if (fall_s[2]) dir_sel_s = D_LEFT;
    else if (fall_s[1]) dir_sel_s = D_UP;
    else                dir_sel_s = D_DOWN;
  end

  // Compress the current line toward its leading end, then merge each pair at most once.
  always_comb begin
    int   j;
    int   o;
    logic skip;
    logic nz;
    for (int k = 0; k < N; k++) line_in_s[LW'(k)] = cells_r[cell_index(dir_r, line_r, k)];
    for (int k = 0; k <= N; k++) comp_s[CW'(k)] = T0;
    for (int k = 0; k < N; k++) line_out_s[LW'(k)] = T0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      nz = (line_in_s[LW'(k)] != T0);
      comp_s[CW'(j)] = nz ? line_in_s[LW'(k)] : comp_s[CW'(j)];
      j = j + int'(nz);
    end
    o = 0;
    skip = 1'b0;
    add_s = 32'd0;
    for (int k = 0; k < N; k++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp_s[CW'(k)] != T0 && comp_s[CW'(k)] == comp_s[CW'(k + 1)] &&
                   comp_s[CW'(k)] != TMAX) begin
        line_out_s[LW'(o)] = comp_s[CW'(k)] + TW'(1);
        add_s = add_s + (32'd1 << (32'(comp_s[CW'(k)]) + 32'd1));
        o = o + 1;
        skip = 1'b1;
      end else begin
        line_out_s[LW'(o)] = comp_s[CW'(k)];
        o = o + int'(comp_s[CW'(k)] != T0);
      end
    end
    diff_s = 1'b0;
    for (int k = 0; k < N; k++) diff_s = diff_s | (line_out_s[LW'(k)] != line_in_s[LW'(k)]);
  end

  // Find the first empty cell at or after the LFSR start index, wrapping around.
  always_comb begin
    int   start;
    int   idx;
    logic hit;
    start = int'(lfsr_r[GW-1:0]) % NN;
    gen_found_s = 1'b0;
    gen_idx_s = {GW{1'b0}};
    for (int k = 0; k < NN; k++) begin
      idx = (start + k) % NN;
      hit = !gen_found_s && (cells_r[GW'(idx)] == T0);
      gen_idx_s = hit ? GW'(idx) : gen_idx_s;
      gen_found_s = gen_found_s | hit;
    end
    gen_val_s = (lfsr_r[15:13] == 3'b111) ? TW'(2) : TW'(1);
  end

  // Whole-grid status: winning tile present, empty cell present, adjacent equal pair present.
  always_comb begin
    logic [TW-1:0] v;
    win_hit_s = 1'b0;
    empty_s = 1'b0;
    pair_s = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        v = cells_r[GW'(r * N + c)];
        win_hit_s = win_hit_s | (v >= TW'(WIN_EXP));
        empty_s = empty_s | (v == T0);
        pair_s = pair_s | ((c < N - 1) && v != T0 && v == cells_r[GW'(r * N + c + 1)]);
        pair_s = pair_s | ((r < N - 1) && v != T0 && v == cells_r[GW'((r + 1) * N + c)]);
      end
    end
  end

  // Game FSM next-state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_INIT:      state_s = S_FIRST_GEN;
      S_FIRST_GEN: state_s = first_r ? S_PLAY : S_FIRST_GEN;
      S_PLAY: begin
        if (bus.load_en) state_s = S_CHECK;
        else if (req_s)  state_s = S_SLIDE;
        else             state_s = S_PLAY;
      end
      S_SLIDE:     state_s = (line_r == LW'(N - 1)) ? S_CHECK : S_SLIDE;
      S_CHECK: begin
        if (win_hit_s)              state_s = S_WIN;
        else if (changed_r)         state_s = S_GEN;
        else if (!empty_s && !pair_s) state_s = S_LOSE;
        else                        state_s = S_PLAY;
      end
      S_GEN:       state_s = S_CHECK;
      S_WIN:       state_s = S_WIN;
      S_LOSE:      state_s = S_LOSE;
      default:     state_s = S_INIT;
    endcase
  end

  // Game FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_INIT;
    else       state_r <= state_s;
  end

  // Grid, score, LFSR, button history and move bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NN; i++) cells_r[GW'(i)] <= T0;
      score_r   <= {SW{1'b0}};
      lfsr_r    <= SEED;
      prev_r    <= 4'b0000;
      changed_r <= 1'b0;
      first_r   <= 1'b0;
      dir_r     <= D_RIGHT;
      line_r    <= {LW{1'b0}};
    end else begin
      lfsr_r <= lfsr_nxt_s;
      prev_r <= cur_s;
      case (state_r)
        S_INIT: begin
          for (int i = 0; i < NN; i++) cells_r[GW'(i)] <= T0;
          first_r <= 1'b0;
        end
        S_FIRST_GEN: begin
          if (gen_found_s) cells_r[gen_idx_s] <= gen_val_s;
          first_r <= 1'b1;
        end
        S_PLAY: begin
          if (bus.load_en) begin
            for (int i = 0; i < NN; i++) cells_r[GW'(i)] <= bus.load_grid[i*TW +: TW];
            changed_r <= 1'b0;
          end else if (req_s) begin
            dir_r     <= dir_sel_s;
            line_r    <= {LW{1'b0}};
            changed_r <= 1'b0;
          end
        end
        S_SLIDE: begin
          for (int k = 0; k < N; k++) cells_r[cell_index(dir_r, line_r, k)] <= line_out_s[LW'(k)];
          score_r   <= score_nxt_s;
          changed_r <= changed_r | diff_s;
          line_r    <= line_r + LW'(1);
        end
        S_GEN: begin
          if (gen_found_s) cells_r[gen_idx_s] <= gen_val_s;
          changed_r <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they line up with state_o.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b1;
      win_r  <= 1'b0;
      lose_r <= 1'b0;
    end else begin
      busy_r <= (state_s != S_PLAY);
      win_r  <= (state_s == S_WIN);
      lose_r <= (state_s == S_LOSE);
    end
  end

  // Pack cells into the flat row-major grid bus.
  always_comb begin
    for (int i = 0; i < NN; i++) grid_s[i*TW +: TW] = cells_r[GW'(i)];
  end

  assign bus.grid    = grid_s;
  assign bus.score   = score_r;
  assign bus.state_o = state_r;
  assign bus.busy    = busy_r;
  assign bus.win     = win_r;
  assign bus.lose    = lose_r;
endmodule
